// File: rtl/svfloat_muldiv_sched.sv
// ============================================================================
// Module      : svfloat_muldiv_sched
// Description : Round-robin scheduler that feeds NREQ requesters into one
//               fixed-latency float32 mul/div unit and returns tagged results
//               through an in-order response FIFO with credit-based issue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module svfloat_muldiv_sched #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_div,
    input  logic [NREQ*32-1:0]      req_lhs,
    input  logic [NREQ*32-1:0]      req_rhs,
    output logic                    fu_valid,
    output logic                    fu_div,
    output logic [31:0]             fu_lhs,
    output logic [31:0]             fu_rhs,
    input  logic [31:0]             fu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [31:0]             rsp_result,
    output logic                    busy
);

    localparam int c_IDW = $clog2(NREQ);
    localparam int c_AW  = $clog2(DEPTH);
    localparam int c_CW  = $clog2(DEPTH + 1);
    localparam logic [c_IDW:0] c_NREQ  = (c_IDW + 1)'(NREQ);
    localparam logic [c_CW:0]  c_DEPTH = (c_CW + 1)'(DEPTH);

    logic [c_IDW-1:0]                r_ptr;
    logic [c_CW-1:0]                 r_inflight;
    logic [c_CW-1:0]                 r_count;
    logic [c_AW-1:0]                 r_wp;
    logic [c_AW-1:0]                 r_rp;
    logic [LATENCY-1:0]              r_pv;
    logic [LATENCY-1:0][c_IDW-1:0]   r_pid;
    logic [c_IDW+31:0]               r_mem [DEPTH];

    logic [NREQ-1:0]  w_rot;
    logic             w_found;
    logic [c_IDW-1:0] w_off;
    logic [c_IDW:0]   w_sum;
    logic [c_IDW-1:0] w_gidx;
    logic [c_CW:0]    w_occ;
    logic             w_credit;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;

    // Rotate so that bit 0 is the requester at the round-robin pointer.
    assign w_rot = NREQ'({req_valid, req_valid} >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = c_IDW'(k);
            end
        end
    end

    assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_gidx   = (w_sum >= c_NREQ) ? c_IDW'(w_sum - c_NREQ) : w_sum[c_IDW-1:0];

    // Credit uses registered occupancy only, so a pop frees a slot next cycle.
    assign w_occ    = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_credit = (w_occ < c_DEPTH);
    assign w_issue  = rst_n & w_found & w_credit;

    assign req_ready = w_issue ? (NREQ'(1) << w_gidx) : '0;
    assign fu_valid  = w_issue;
    assign fu_div    = w_issue & req_div[w_gidx];
    assign fu_lhs    = w_issue ? req_lhs[{w_gidx, 5'd0} +: 32] : 32'h0;
    assign fu_rhs    = w_issue ? req_rhs[{w_gidx, 5'd0} +: 32] : 32'h0;

    assign w_push     = r_pv[LATENCY-1];
    assign rsp_valid  = (r_count != '0);
    assign w_pop      = rsp_valid & rsp_ready;
    assign rsp_id     = rsp_valid ? r_mem[r_rp][c_IDW+31:32] : '0;
    assign rsp_result = rsp_valid ? r_mem[r_rp][31:0] : 32'h0;
    assign busy       = (r_inflight != '0) | (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_gidx == c_IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
        end
    end

    // Tag pipeline mirrors the unit latency; clearing it drops in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv  <= '0;
            r_pid <= '0;
        end else begin
            r_pv[0]  <= w_issue;
            r_pid[0] <= w_gidx;
            for (int s = 1; s < LATENCY; s++) begin
                r_pv[s]  <= r_pv[s-1];
                r_pid[s] <= r_pid[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_count    <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
        end else begin
            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {r_pid[LATENCY-1], fu_result};
    end

endmodule

`default_nettype wire

// File: tb/tb_svfloat_muldiv_sched.sv
// ============================================================================
// Module      : tb_svfloat_muldiv_sched
// Description : Directed bench for svfloat_muldiv_sched (NREQ=4, LATENCY=2,
//               DEPTH=4) with a power-of-two exponent-arithmetic unit model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_svfloat_muldiv_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   req_div;
    logic [127:0] req_lhs;
    logic [127:0] req_rhs;
    logic         fu_valid;
    logic         fu_div;
    logic [31:0]  fu_lhs;
    logic [31:0]  fu_rhs;
    logic [31:0]  fu_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] r_m1 = 32'h0;
    logic [31:0] r_m2 = 32'h0;

    svfloat_muldiv_sched #(.NREQ(4), .LATENCY(2), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_div    (req_div),
        .req_lhs    (req_lhs),
        .req_rhs    (req_rhs),
        .fu_valid   (fu_valid),
        .fu_div     (fu_div),
        .fu_lhs     (fu_lhs),
        .fu_rhs     (fu_rhs),
        .fu_result  (fu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Exact for power-of-two operands: mul adds exponents, div subtracts.
    function automatic logic [31:0] fu_model(input logic d, input logic [31:0] a, input logic [31:0] b);
        return d ? (a - (b - 32'h3F800000)) : (a + b - 32'h3F800000);
    endfunction

    always @(posedge clk) begin
        r_m1 <= fu_valid ? fu_model(fu_div, fu_lhs, fu_rhs) : 32'h0;
        r_m2 <= r_m1;
    end
    assign fu_result = r_m2;

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_ops();
        for (int i = 0; i < 4; i++) begin
            req_lhs[32*i +: 32] = 32'h3F800000 + ((i + 1) << 23);
            req_rhs[32*i +: 32] = 32'h40000000;
        end
        req_div = 4'b1010;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        set_ops();
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL reset_fu_valid: got %b want 0", fu_valid); end
        checks++; if (fu_lhs !== 32'h0 || fu_rhs !== 32'h0 || fu_div !== 1'b0) begin errors++; $display("FAIL reset_fu_ops: got %h %h %b want 0", fu_lhs, fu_rhs, fu_div); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0 || rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %0d %h want 0 0", rsp_id, rsp_result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        req_valid       = 4'b0100;
        req_div         = 4'b0000;
        req_lhs[95:64]  = 32'h3F800000;
        req_rhs[95:64]  = 32'h40000000;
        rsp_ready       = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        checks++; if (fu_valid !== 1'b1 || fu_div !== 1'b0) begin errors++; $display("FAIL single_fu_valid: got %b/%b want 1/0", fu_valid, fu_div); end
        checks++; if (fu_lhs !== 32'h3F800000 || fu_rhs !== 32'h40000000) begin errors++; $display("FAIL single_fu_ops: got %h %h want 3f800000 40000000", fu_lhs, fu_rhs); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req_valid = 4'b0000;
            #1;
            if (c < 3) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: cycle %0d got %b want 0", c, rsp_valid); end
            end else if (c == 3) begin
                checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
                checks++; if (rsp_id !== 2'd2 || rsp_result !== 32'h40000000) begin errors++; $display("FAIL single_rsp_data: got %0d %h want 2 40000000", rsp_id, rsp_result); end
            end else begin
                checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drained: got %b/%b want 0/0", rsp_valid, busy); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_res [4];
        logic [3:0]  one;
        int          g;
        exp_res[0] = 32'h40800000;
        exp_res[1] = 32'h40000000;
        exp_res[2] = 32'h41800000;
        exp_res[3] = 32'h41000000;
        one = 4'b0001;
        apply_reset();
        set_ops();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req_valid = (k < 6) ? 4'b1111 : 4'b0000;
            rsp_ready = 1'b1;
            #1;
            if (k < 6) begin
                g = k % 4;
                checks++; if (req_ready !== (one << g)) begin errors++; $display("FAIL b2b_grant: cycle %0d got %b want %b", k, req_ready, one << g); end
                checks++; if (fu_lhs !== req_lhs[32*g +: 32] || fu_div !== req_div[g]) begin errors++; $display("FAIL b2b_fu_ops: cycle %0d got %h/%b", k, fu_lhs, fu_div); end
            end else begin
                checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL b2b_idle: cycle %0d got %b want 0000", k, req_ready); end
            end
            if (k >= 3 && k < 9) begin
                g = (k - 3) % 4;
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_result !== exp_res[g]) begin
                    errors++; $display("FAIL b2b_rsp: cycle %0d got v=%b id=%0d res=%h want v=1 id=%0d res=%h", k, rsp_valid, rsp_id, rsp_result, g, exp_res[g]);
                end
            end
        end
    endtask

    task automatic test_credit();
        int  issues;
        logic exp_issue;
        issues = 0;
        apply_reset();
        set_ops();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            rsp_ready = (k == 7);
            #1;
            exp_issue = (k < 4) || (k == 8);
            if (fu_valid === 1'b1) issues++;
            checks++; if (fu_valid !== exp_issue) begin errors++; $display("FAIL credit_issue: cycle %0d got %b want %b", k, fu_valid, exp_issue); end
            if (k == 7) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL credit_pop: got v=%b id=%0d want 1 0", rsp_valid, rsp_id); end
            end
            if (k == 8) begin
                checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL credit_regrant: got %b want 0001", req_ready); end
            end
        end
        checks++; if (issues != 5) begin errors++; $display("FAIL credit_total: got %0d want 5", issues); end
    endtask

    task automatic test_ptr();
        apply_reset();
        set_ops();
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL ptr_grant3: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ptr_grant1: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b1011;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL ptr_after1: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_inflight();
        apply_reset();
        set_ops();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'b0111;
            rsp_ready = 1'b0;
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL flush_pre: got v=%b busy=%b want 1 1", rsp_valid, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_during: got v=%b busy=%b want 0 0", rsp_valid, busy); end
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_after: cycle %0d got v=%b busy=%b want 0 0", k, rsp_valid, busy); end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_div   = 4'b0000;
        req_lhs   = '0;
        req_rhs   = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_credit();
        test_ptr();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/svfloat_muldiv_sched.md
SVFLOAT_MULDIV_SCHED -- requirements
Module: svfloat_muldiv_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter LATENCY, default 2, fixed issue-to-result latency of the shared float32 mul/div unit (1..8 cycles).
REQ-003 SHALL have parameter DEPTH, default 4, result FIFO entries (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester operation pending.
REQ-007 SHALL have port req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
REQ-008 SHALL have port req_div  input  NREQ  operation select per requester: 0 multiply, 1 divide.
REQ-009 SHALL have port req_lhs  input  NREQ*32  float32 left operands; requester i at bits [32*i+31:32*i].
REQ-010 SHALL have port req_rhs  input  NREQ*32  float32 right operands; same packing.
REQ-011 SHALL have port fu_valid  output  1  operation issued to the shared unit this cycle.
REQ-012 SHALL have port fu_div  output  1  operation select to the shared unit.
REQ-013 SHALL have port fu_lhs  output  32  left operand to the shared unit.
REQ-014 SHALL have port fu_rhs  output  32  right operand to the shared unit.
REQ-015 SHALL have port fu_result  input  32  unit result; valid exactly LATENCY cycles after fu_valid.
REQ-016 SHALL have port rsp_valid  output  1  response available (FIFO non-empty).
REQ-017 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-018 SHALL have port rsp_id  output  $clog2(NREQ)  index of the requester owning the response.
REQ-019 SHALL have port rsp_result  output  32  float32 result.
REQ-020 SHALL have port busy  output  1  high while any operation is in flight or the FIFO is non-empty.

Function
REQ-021 SHALL arbitrate round-robin: search starts at pointer ptr, first i with req_valid[i] wins; after a grant to i, ptr <= (i+1) mod NREQ; ptr unchanged when nothing is granted.
REQ-022 SHALL grant only when credit = DEPTH - (inflight + fifo_count) > 0, using registered counts; a pop in the same cycle frees credit from the next cycle only.
REQ-023 SHALL drive req_ready combinationally from req_valid, ptr and credit; at most one bit high; req_ready[i] never high while req_valid[i] is low.
REQ-024 SHALL drive fu_valid = |(req_valid & req_ready), and fu_div/fu_lhs/fu_rhs from the granted requester in the same cycle; when fu_valid is low, fu_lhs/fu_rhs/fu_div SHALL be 0.
REQ-025 SHALL carry {valid, id} through a LATENCY-stage shift register; at stage exit, fu_result SHALL be written to the FIFO with that id.
REQ-026 SHALL give issue-to-response latency LATENCY+1: issue in cycle t, rsp_valid first high in cycle t+LATENCY+1 (no FIFO bypass).
REQ-027 SHALL count inflight: +1 on issue, -1 on stage exit, both in one cycle leaves it unchanged.
REQ-028 SHALL pop the FIFO on rsp_valid & rsp_ready; simultaneous push and pop SHALL be legal at any occupancy; overflow is unreachable by REQ-022.
REQ-029 SHALL deliver responses in issue order; rsp_id/rsp_result SHALL hold stable while rsp_valid & !rsp_ready.
REQ-030 SHALL sustain one issue per cycle while credit > 0 and rsp_ready is held high.

Reset
REQ-031 SHALL, while rst_n is low, force req_ready=0, fu_valid=0, fu_lhs=fu_rhs=0, fu_div=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, ptr=0, inflight=0, FIFO empty, all pipeline valids 0.
REQ-032 SHALL discard operations in flight at reset; results returning from the unit afterwards SHALL never appear on rsp.

Verification
REQ-033 SHALL cover, with LATENCY=2, DEPTH=4: only req 2 valid, mul, lhs=0x3F800000, rhs=0x40000000, unit model returns 0x40000000 -> req_ready=0100 and fu_valid in cycle 0; rsp_valid in cycle 3 with rsp_id=2, rsp_result=0x40000000.
REQ-034 SHALL cover: all req_valid=1111 held, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; responses in that id order.
REQ-035 SHALL cover: all valid, rsp_ready=0 -> exactly 4 issues, then req_ready=0000; one pop -> exactly one further issue the following cycle.
REQ-036 SHALL cover: last grant to 3, next cycle only req 1 valid -> req_ready=0010, ptr becomes 2.
REQ-037 SHALL cover: rst_n low for 1 cycle with 2 in flight and 1 in FIFO -> rsp_valid=0, busy=0 immediately; after release no response appears within 10 cycles without new requests.
